// File: rtl/alarm_pkg.sv
// +--------------------------------------------------------------------+
// | alarm_pkg : shared state encoding and default timing constants      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } alarm_st_t;

    localparam int RING_SEC_D   = 60;
    localparam int SNOOZE_MIN_D = 9;
    localparam int MAX_SNOOZE_D = 3;

endpackage

`default_nettype wire

// File: rtl/alarm_ctrl_rise_det.sv
// +--------------------------------------------------------------------+
// | rise_det : one-clock pulse on the rising edge of a level input      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module rise_det #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) r_q <= RST_VAL;
        else     r_q <= din;
    end

    assign pulse = din & ~r_q;

endmodule

`default_nettype wire

// File: rtl/alarm_ctrl.sv
// +--------------------------------------------------------------------+
// | alarm_ctrl : alarm match detection and ring/snooze/auto-off FSM     |
// | Optional snooze support under macro ALARM_SNOOZE_EN                 |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int NS         = 60,
    parameter int NH         = 24,
    parameter int RING_SEC   = RING_SEC_D,
    parameter int SNOOZE_MIN = SNOOZE_MIN_D,
    parameter int MAX_SNOOZE = MAX_SNOOZE_D
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] tsec,
    input  logic [6:0] tmin,
    input  logic [6:0] thrs,
    input  logic [6:0] amin,
    input  logic [6:0] ahrs,
    input  logic       alarmon,
    input  logic       snooze,
    output logic       buzz,
    output logic       snoozing
);

    localparam int c_RING_W = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;
    localparam logic [c_RING_W-1:0] c_RING_LAST = c_RING_W'(RING_SEC - 1);

    alarm_st_t           r_state, w_nxt;
    logic [c_RING_W-1:0] r_ring_ct, w_ring_nxt;
    logic                w_eq, w_trig;
    logic                r_buzz;

    assign w_eq = (tmin == amin) && (thrs == ahrs);

    // Reset value 1 keeps a match already present at reset release silent.
    rise_det #(.RST_VAL(1'b1)) u_eq_det (
        .clk   (clk),
        .rst   (rst),
        .din   (w_eq),
        .pulse (w_trig)
    );

`ifdef ALARM_SNOOZE_EN
    localparam int c_SNZ_LEN = SNOOZE_MIN * NS;
    localparam int c_SNZ_W   = (c_SNZ_LEN > 1) ? $clog2(c_SNZ_LEN) : 1;
    localparam int c_USED_W  = $clog2(MAX_SNOOZE + 1);
    localparam logic [c_SNZ_W-1:0]  c_SNZ_LOAD = c_SNZ_W'(c_SNZ_LEN - 1);
    localparam logic [c_USED_W-1:0] c_USED_MAX = c_USED_W'(MAX_SNOOZE);

    logic [c_SNZ_W-1:0]  r_snz_ct, w_snz_nxt;
    logic [c_USED_W-1:0] r_snz_used, w_used_nxt;
    logic                w_press;
    logic                r_snoozing;

    rise_det #(.RST_VAL(1'b0)) u_snz_det (
        .clk   (clk),
        .rst   (rst),
        .din   (snooze),
        .pulse (w_press)
    );
`endif

    always_comb begin
        w_nxt      = r_state;
        w_ring_nxt = r_ring_ct;
`ifdef ALARM_SNOOZE_EN
        w_snz_nxt  = r_snz_ct;
        w_used_nxt = r_snz_used;
`endif
        case (r_state)
            IDLE: begin
                w_ring_nxt = '0;
`ifdef ALARM_SNOOZE_EN
                w_snz_nxt  = '0;
                w_used_nxt = '0;
`endif
                if (w_trig) w_nxt = RINGING;
            end
            RINGING: begin
                w_ring_nxt = r_ring_ct + c_RING_W'(1);
`ifdef ALARM_SNOOZE_EN
                // Snooze beats the timeout landing on the same edge.
                if (w_press && (r_snz_used < c_USED_MAX)) begin
                    w_nxt      = SNOOZE;
                    w_ring_nxt = '0;
                    w_snz_nxt  = c_SNZ_LOAD;
                    w_used_nxt = r_snz_used + c_USED_W'(1);
                end else
`endif
                if (r_ring_ct == c_RING_LAST) begin
                    w_nxt      = IDLE;
                    w_ring_nxt = '0;
                end
            end
`ifdef ALARM_SNOOZE_EN
            SNOOZE: begin
                w_ring_nxt = '0;
                if (r_snz_ct == '0) w_nxt = RINGING;
                else                w_snz_nxt = r_snz_ct - c_SNZ_W'(1);
            end
`endif
            default: w_nxt = IDLE;
        endcase
        if (!alarmon) w_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ring_ct <= '0;
            r_buzz    <= 1'b0;
        end else begin
            r_state   <= w_nxt;
            r_ring_ct <= w_ring_nxt;
            r_buzz    <= (w_nxt == RINGING);
        end
    end

    assign buzz = r_buzz;

`ifdef ALARM_SNOOZE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_snz_ct   <= '0;
            r_snz_used <= '0;
            r_snoozing <= 1'b0;
        end else begin
            r_snz_ct   <= w_snz_nxt;
            r_snz_used <= w_used_nxt;
            r_snoozing <= (w_nxt == SNOOZE);
        end
    end

    assign snoozing = r_snoozing;

    logic w_unused_inputs;
    assign w_unused_inputs = ^{tsec, (thrs >= 7'(NH))};
`else
    assign snoozing = 1'b0;

    logic w_unused_inputs;
    assign w_unused_inputs = ^{tsec, snooze, (thrs >= 7'(NH)),
                               (7'(SNOOZE_MIN) == 7'(MAX_SNOOZE)), (7'(NS) == 7'd0)};
`endif

endmodule

`default_nettype wire

// File: tb/tb_alarm_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_alarm_ctrl : directed self-checking bench for alarm_ctrl         |
// | Expectations follow ALARM_SNOOZE_EN when it is defined.             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_alarm_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] tsec, tmin, thrs, amin, ahrs;
    logic       alarmon, snooze;
    logic       buzz, snoozing;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alarm_ctrl #(
        .NS         (60),
        .NH         (24),
        .RING_SEC   (5),
        .SNOOZE_MIN (1),
        .MAX_SNOOZE (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tsec     (tsec),
        .tmin     (tmin),
        .thrs     (thrs),
        .amin     (amin),
        .ahrs     (ahrs),
        .alarmon  (alarmon),
        .snooze   (snooze),
        .buzz     (buzz),
        .snoozing (snoozing)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Time 07:29 for one edge, then 07:30; alarm rings after the next edge.
    task automatic start_ring(input string tag);
        tmin = 7'd29;
        tick(1);
        tmin = 7'd30;
        tick(1);
        total++;
        if (buzz !== 1'b1 || snoozing !== 1'b0) begin
            bad++;
            $display("FAIL %s start: buzz=%b snoozing=%b want 1/0", tag, buzz, snoozing);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; tsec = 7'd0; thrs = 7'd7; tmin = 7'd29;
        ahrs = 7'd7; amin = 7'd30; alarmon = 1'b1; snooze = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
        total++;
        if (buzz !== 1'b0 || snoozing !== 1'b0) begin
            bad++;
            $display("FAIL reset: buzz=%b snoozing=%b want 0/0", buzz, snoozing);
        end
    endtask

    task automatic test_ring;
        start_ring("ring");
        for (int i = 0; i < 4; i++) begin
            tick(1);
            total++;
            if (buzz !== 1'b1) begin
                bad++;
                $display("FAIL ring_hold[%0d]: buzz=%b want 1", i, buzz);
            end
        end
        tick(1);
        total++;
        if (buzz !== 1'b0) begin
            bad++;
            $display("FAIL ring_autooff: buzz=%b want 0", buzz);
        end
        tick(3);
        total++;
        if (buzz !== 1'b0) begin
            bad++;
            $display("FAIL ring_no_rering: buzz=%b want 0", buzz);
        end
    endtask

    task automatic test_snooze;
        start_ring("snooze");
        tick(1);
        snooze = 1'b1;
        tick(1);
        snooze = 1'b0;
`ifdef ALARM_SNOOZE_EN
        total++;
        if (buzz !== 1'b0 || snoozing !== 1'b1) begin
            bad++;
            $display("FAIL snooze_enter: buzz=%b snoozing=%b want 0/1", buzz, snoozing);
        end
        snooze = 1'b1;
        tick(2);
        snooze = 1'b0;
        tick(57);
        total++;
        if (buzz !== 1'b0 || snoozing !== 1'b1) begin
            bad++;
            $display("FAIL snooze_hold: buzz=%b snoozing=%b want 0/1", buzz, snoozing);
        end
        tick(1);
        total++;
        if (buzz !== 1'b1 || snoozing !== 1'b0) begin
            bad++;
            $display("FAIL snooze_rering: buzz=%b snoozing=%b want 1/0", buzz, snoozing);
        end
        tick(4);
        total++;
        if (buzz !== 1'b1) begin
            bad++;
            $display("FAIL snooze_ring_hold: buzz=%b want 1", buzz);
        end
        tick(1);
`else
        total++;
        if (buzz !== 1'b1 || snoozing !== 1'b0) begin
            bad++;
            $display("FAIL snooze_ignored: buzz=%b snoozing=%b want 1/0", buzz, snoozing);
        end
        tick(2);
        total++;
        if (buzz !== 1'b1) begin
            bad++;
            $display("FAIL snooze_ignored_hold: buzz=%b want 1", buzz);
        end
        tick(1);
`endif
        total++;
        if (buzz !== 1'b0 || snoozing !== 1'b0) begin
            bad++;
            $display("FAIL snooze_autooff: buzz=%b snoozing=%b want 0/0", buzz, snoozing);
        end
    endtask

    task automatic test_quota;
        start_ring("quota");
`ifdef ALARM_SNOOZE_EN
        for (int n = 0; n < 3; n++) begin
            snooze = 1'b1;
            tick(1);
            snooze = 1'b0;
            total++;
            if (snoozing !== 1'b1) begin
                bad++;
                $display("FAIL quota_snooze[%0d]: snoozing=%b want 1", n, snoozing);
            end
            tick(60);
            total++;
            if (buzz !== 1'b1) begin
                bad++;
                $display("FAIL quota_rering[%0d]: buzz=%b want 1", n, buzz);
            end
        end
`endif
        snooze = 1'b1;
        tick(1);
        snooze = 1'b0;
        total++;
        if (buzz !== 1'b1 || snoozing !== 1'b0) begin
            bad++;
            $display("FAIL quota_4th_ignored: buzz=%b snoozing=%b want 1/0", buzz, snoozing);
        end
        tick(3);
        total++;
        if (buzz !== 1'b1) begin
            bad++;
            $display("FAIL quota_hold: buzz=%b want 1", buzz);
        end
        tick(1);
        total++;
        if (buzz !== 1'b0) begin
            bad++;
            $display("FAIL quota_autooff: buzz=%b want 0", buzz);
        end
    endtask

    task automatic test_alarmon_drop;
        start_ring("drop_ring");
        tick(1);
        alarmon = 1'b0;
        tick(1);
        total++;
        if (buzz !== 1'b0 || snoozing !== 1'b0) begin
            bad++;
            $display("FAIL drop_ring: buzz=%b snoozing=%b want 0/0", buzz, snoozing);
        end
        alarmon = 1'b1;
        tick(3);
        total++;
        if (buzz !== 1'b0) begin
            bad++;
            $display("FAIL drop_ring_no_rering: buzz=%b want 0", buzz);
        end
`ifdef ALARM_SNOOZE_EN
        start_ring("drop_snz");
        snooze = 1'b1;
        tick(1);
        snooze = 1'b0;
        tick(5);
        total++;
        if (snoozing !== 1'b1) begin
            bad++;
            $display("FAIL drop_snz_pre: snoozing=%b want 1", snoozing);
        end
        alarmon = 1'b0;
        tick(1);
        total++;
        if (buzz !== 1'b0 || snoozing !== 1'b0) begin
            bad++;
            $display("FAIL drop_snz: buzz=%b snoozing=%b want 0/0", buzz, snoozing);
        end
        alarmon = 1'b1;
        tick(70);
        total++;
        if (buzz !== 1'b0 || snoozing !== 1'b0) begin
            bad++;
            $display("FAIL drop_snz_no_rering: buzz=%b snoozing=%b want 0/0", buzz, snoozing);
        end
`endif
    endtask

    task automatic test_rst_match;
        start_ring("rst_match");
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        total++;
        if (buzz !== 1'b0 || snoozing !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_ring: buzz=%b snoozing=%b want 0/0", buzz, snoozing);
        end
        tick(3);
        total++;
        if (buzz !== 1'b0) begin
            bad++;
            $display("FAIL rst_no_ring: buzz=%b want 0", buzz);
        end
        amin = 7'd31;
        tick(1);
        amin = 7'd30;
        tick(1);
        total++;
        if (buzz !== 1'b1) begin
            bad++;
            $display("FAIL rst_reset_alarm_ring: buzz=%b want 1", buzz);
        end
        tick(5);
        total++;
        if (buzz !== 1'b0) begin
            bad++;
            $display("FAIL rst_ring_autooff: buzz=%b want 0", buzz);
        end
    endtask

    task automatic test_boundary;
        start_ring("boundary");
        tick(4);
        snooze = 1'b1;
        tick(1);
        snooze = 1'b0;
`ifdef ALARM_SNOOZE_EN
        total++;
        if (buzz !== 1'b0 || snoozing !== 1'b1) begin
            bad++;
            $display("FAIL boundary_snooze_wins: buzz=%b snoozing=%b want 0/1", buzz, snoozing);
        end
`else
        total++;
        if (buzz !== 1'b0 || snoozing !== 1'b0) begin
            bad++;
            $display("FAIL boundary_autooff: buzz=%b snoozing=%b want 0/0", buzz, snoozing);
        end
`endif
        alarmon = 1'b0;
        tick(1);
        alarmon = 1'b1;
    endtask

    initial begin
        test_reset();
        test_ring();
        test_snooze();
        test_quota();
        test_alarmon_drop();
        test_rst_match();
        test_boundary();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alarm_ctrl.md
# alarm_ctrl

Alarm sequencer between the clock/alarm registers and the buzzer output of the digital alarm clock. It consumes current time (sec/min/hrs) and alarm setting (min/hrs) and detects the instant the time reaches the alarm. It then drives `buzz` through a ring / snooze / auto-off state machine. It replaces the purely combinational compare that would otherwise drive `Buzz` directly.

## Interface
Parameters:
- `NS`, 60: seconds per minute; also minutes per hour.
- `NH`, 24: hours per day (counter range only; not used in arithmetic).
- `RING_SEC`, 60: ring duration in clocks before auto-off.
- `SNOOZE_MIN`, 9: snooze duration in minutes. Snooze length = `SNOOZE_MIN*NS` clocks.
- `MAX_SNOOZE`, 3: snoozes allowed per alarm event.

Ports:
- `clk`, in, 1: the 1 Hz `Pulse` tick; all state changes on its rising edge.
- `rst`, in, 1: synchronous, active-high.
- `tsec`, in, 7: current seconds, 0..NS-1 (status only; not used in the match).
- `tmin`, `thrs`, in, 7 each: current time.
- `amin`, `ahrs`, in, 7 each: alarm setting.
- `alarmon`, in, 1: alarm enable level.
- `snooze`, in, 1: snooze button level; acted on at its rising edge.
- `buzz`, out, 1: registered; high only in RINGING.
- `snoozing`, out, 1: registered; high only in SNOOZE.

## Operation
- Match: `eq = (tmin==amin) && (thrs==ahrs)`. Registered copy `eq_q`. Trigger = `eq && !eq_q`, i.e. the rising edge of the match.
- Snooze press = `snooze && !snooze_q`, with `snooze_q` registered.
- States:
  - IDLE: to RINGING on trigger while `alarmon`=1. Clears the ring and snooze counters and `snz_used`.
  - RINGING: `ring_ct` increments each clock.
    - On snooze press with `snz_used<MAX_SNOOZE`: go to SNOOZE; load `snz_ct = SNOOZE_MIN*NS-1`; increment `snz_used`.
    - Else at `ring_ct==RING_SEC-1`: go to IDLE (auto-off).
  - SNOOZE: `snz_ct` decrements. At `snz_ct==0`: go to RINGING with `ring_ct` cleared. Snooze presses here are ignored.
- Priority, highest first:
  1. `rst`
  2. `alarmon`=0, which forces IDLE from any state on that edge
  3. snooze press
  4. ring timeout
- Snooze press on the same edge as `ring_ct==RING_SEC-1`: snooze wins if the quota remains.
- With the quota exhausted, snooze presses are ignored; the ring runs to auto-off.
- A trigger in RINGING or SNOOZE is ignored. It can only occur if time or alarm is re-set mid-event.
- Re-setting the alarm so that it equals the current time produces a trigger. This is intended.
- Widths:
  - `ring_ct`: $clog2(RING_SEC) bits.
  - `snz_ct`: $clog2(SNOOZE_MIN*NS) bits (10 bits at defaults, max 539).
  - `snz_used`: $clog2(MAX_SNOOZE+1) bits.
  - No wrap: counters saturate by state exit.

## Timing
- Reset values:
  - `buzz`=0, `snoozing`=0.
  - state=IDLE; all counters 0.
  - `snooze_q`=0.
  - `eq_q`=1, so a match already present at reset release does not ring.
- Latency: `tmin`/`thrs` reach the alarm after clock edge k. `buzz` goes high after edge k+1.
- Ring length: `buzz` stays high for exactly `RING_SEC` clocks if untouched.
- Snooze: the press is sampled at edge j, and `buzz` goes low after edge j. `buzz` returns high after edge j+`SNOOZE_MIN*NS`.
- `alarmon` falling, sampled at edge m: `buzz` and `snoozing` are low after edge m.
- Reset mid-RINGING or mid-SNOOZE: outputs are low after the reset edge. No re-ring until the next match rising edge after `eq` first goes low.

## Configuration
- Macro `ALARM_SNOOZE_EN`.
- Defined: snooze behaviour as above.
- Undefined:
  - The `snooze` input is ignored and SNOOZE is unreachable.
  - `snz_ct`, `snz_used` and `snooze_q` are not built.
  - `snoozing` is tied 0.
  - RINGING exits only by timeout or `alarmon`=0.

## Structure
- Shared package `alarm_pkg`:
  - state enum `alarm_st_t` {IDLE, RINGING, SNOOZE}
  - default constants `RING_SEC_D`, `SNOOZE_MIN_D`, `MAX_SNOOZE_D`
- Sub-module `rise_det` (clk, rst, reset value parameter, in → pulse). It is instantiated twice: for `eq` (reset value 1) and for `snooze` (reset value 0).

## Test plan
- Test parameters: RING_SEC=5, SNOOZE_MIN=1, NS=60.
- Set alarm 07:30, advance time 07:29→07:30 at edge 10 → `buzz`=1 from after edge 11 for 5 clocks, then 0; state IDLE.
- While ringing, pulse `snooze` at edge 13 → `buzz`=0 and `snoozing`=1 after edge 13; `buzz`=1 again after edge 73.
- Snooze 3 times, then press a 4th time → 4th press ignored; `buzz` auto-offs after 5 clocks; with `ALARM_SNOOZE_EN` undefined, every press is ignored.
- Drop `alarmon` during RINGING, and separately during SNOOZE → both outputs 0 next edge; no re-ring while time stays 07:30.
- Assert `rst` with time already equal to alarm → no ring after release. Then move the alarm away and back → ring.
- Snooze press on the same edge as `ring_ct`==4 → SNOOZE entered, not IDLE.
